// File: rtl/clock_mode_fsm_param.sv
// clock_mode_fsm_param: mode sequencer with button debounce, edit timeout, page select.
// Optional edited-field blink: define CLOCK_MODE_BLINK_EN.
module clock_mode_fsm_param #(
  parameter int N_FIELDS   = 7,
  parameter int PAGE_SPLIT = 3,
  parameter int DB_CYCLES  = 4,
  parameter int TIMEOUT_S  = 10,
  localparam int FW = (N_FIELDS > 2) ? $clog2(N_FIELDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_button,
  input  logic                display_switch,
  input  logic                tick_1s,
  output logic [N_FIELDS-1:0] enable_display,
  output logic [N_FIELDS-1:0] enable_cnt,
  output logic                enable_pulse_1s,
  output logic                edit_active,
  output logic [FW-1:0]       edit_field
);

  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_S > 0);

  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_EN ? TIMEOUT_S - 1 : 0);
  localparam logic [FW-1:0] LAST_F  = FW'(N_FIELDS - 1);
  localparam logic [FW-1:0] SPLIT_F = FW'(PAGE_SPLIT);

  localparam logic [N_FIELDS-1:0] PAGE0 =
    N_FIELDS'((32'd1 << PAGE_SPLIT) - 32'd1);
  localparam logic [N_FIELDS-1:0] PAGE1 = ~PAGE0;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_EDIT = 1'b1;

  logic          sync1, sync2;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic          press;
  logic [0:0]    mode, mode_d;
  logic [FW-1:0] field, field_d;
  logic [TW-1:0] to_cnt;
  logic          edit;
  logic          to_hit;
  logic          p_enter, p_wrap, p_step, t_exit;
  logic [N_FIELDS-1:0] onehot;
  logic [N_FIELDS-1:0] blink_mask;
  logic          page_sel;

  assign edit   = (mode == ST_EDIT);
  assign onehot = N_FIELDS'(1) << field;

  // press fires on the cycle the stable level rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= mode_button;
      sync2 <= sync1;
      press <= sync2 && !stable && (db_cnt == DB_LAST);
      if (sync2 != stable) begin
        if (db_cnt == DB_LAST) begin
          stable <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign to_hit  = TO_EN && edit && tick_1s && (to_cnt == TO_LAST);
  assign p_enter = press && !edit;
  assign p_wrap  = press && edit && (field == LAST_F);
  assign p_step  = press && edit && (field != LAST_F);
  assign t_exit  = to_hit && !press;

  always_comb begin
    mode_d  = mode;
    field_d = field;
    unique case (1'b1)
      p_enter: begin
        mode_d  = ST_EDIT;
        field_d = '0;
      end
      p_wrap, t_exit: begin
        mode_d  = ST_RUN;
        field_d = '0;
      end
      p_step: field_d = field + FW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode   <= ST_RUN;
      field  <= '0;
      to_cnt <= '0;
    end else begin
      mode  <= mode_d;
      field <= field_d;
      if (!edit || press || to_hit)
        to_cnt <= '0;
      else if (TO_EN && tick_1s)
        to_cnt <= to_cnt + TW'(1);
    end
  end

`ifdef CLOCK_MODE_BLINK_EN
  logic phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      phase <= 1'b0;
    else if (mode_d == ST_RUN)
      phase <= 1'b0;
    else if (edit && tick_1s)
      phase <= ~phase;
  end

  assign blink_mask = (edit && phase) ? onehot : '0;
`else
  assign blink_mask = '0;
`endif

  // reset forces page 0 even though the switch is sampled live
  always_comb begin
    page_sel = edit ? (field >= SPLIT_F)
                    : (display_switch && rst);
    enable_display  = (page_sel ? PAGE1 : PAGE0) & ~blink_mask;
    enable_cnt      = edit ? onehot : '0;
    enable_pulse_1s = !edit;
    edit_active     = edit;
    edit_field      = field;
  end

endmodule

// File: tb/tb_clock_mode_fsm_param.sv
// tb_clock_mode_fsm_param: directed bench for clock_mode_fsm_param.
// Blink expectations follow CLOCK_MODE_BLINK_EN.
module tb_clock_mode_fsm_param;

`ifdef CLOCK_MODE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_button = 1'b0;
  logic       display_switch = 1'b0;
  logic       tick_1s = 1'b0;
  logic [6:0] enable_display;
  logic [6:0] enable_cnt;
  logic       enable_pulse_1s;
  logic       edit_active;
  logic [2:0] edit_field;

  int checks = 0;
  int errors = 0;

  clock_mode_fsm_param dut (
    .clk             (clk),
    .rst             (rst),
    .mode_button     (mode_button),
    .display_switch  (display_switch),
    .tick_1s         (tick_1s),
    .enable_display  (enable_display),
    .enable_cnt      (enable_cnt),
    .enable_pulse_1s (enable_pulse_1s),
    .edit_active     (edit_active),
    .edit_field      (edit_field)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    mode_button = 1'b0;
    tick_1s = 1'b0;
    display_switch = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // raw rise after E0; press is consumed at E7, optional tick aligned to it
  task automatic press_tick(input bit with_tick);
    @(posedge clk); #1 mode_button = 1'b1;
    repeat (6) @(posedge clk);
    #1 tick_1s = with_tick;
    @(posedge clk); #1 tick_1s = 1'b0;
    repeat (3) @(posedge clk);
    #1 mode_button = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 tick_1s = 1'b1;
      @(posedge clk); #1 tick_1s = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      mode_button = i[0];
      display_switch = ~i[0];
      tick_1s = i[1];
      @(negedge clk);
      checks++;
      if (enable_pulse_1s !== 1'b1 || enable_cnt !== 7'b0 ||
          enable_display !== 7'b0000111 || edit_active !== 1'b0 ||
          edit_field !== 3'd0) begin
        errors++;
        $display("FAIL reset_outputs: disp=%b cnt=%b pulse=%b act=%b fld=%0d",
                 enable_display, enable_cnt, enable_pulse_1s,
                 edit_active, edit_field);
      end
    end
    @(posedge clk); #1;
    mode_button = 1'b0;
    tick_1s = 1'b0;
    display_switch = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (enable_display !== 7'b0000111) begin
      errors++;
      $display("FAIL run_page0: got %b want 0000111", enable_display);
    end
    display_switch = 1'b1;
    @(negedge clk);
    checks++;
    if (enable_display !== 7'b1111000 || edit_active !== 1'b0) begin
      errors++;
      $display("FAIL run_page1: got %b act=%b want 1111000 act=0",
               enable_display, edit_active);
    end
    display_switch = 1'b0;
  endtask

  task automatic test_debounce();
    do_reset();
    for (int p = 0; p < 8; p++) begin
      @(posedge clk); #1 mode_button = 1'b1;
      repeat (3) @(posedge clk);
      #1 mode_button = 1'b0;
      repeat (5) @(posedge clk);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (edit_active !== 1'b0) begin
      errors++;
      $display("FAIL bounce_reject: edit_active=%b want 0", edit_active);
    end
    @(posedge clk); #1 mode_button = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (edit_active !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: edit_active=%b at +6 want 0", edit_active);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (edit_active !== 1'b1) begin
      errors++;
      $display("FAIL latency_7: edit_active=%b at +7 want 1", edit_active);
    end
    repeat (3) @(posedge clk);
    #1 mode_button = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++;
    if (enable_cnt !== 7'b0000001 || enable_pulse_1s !== 1'b0 ||
        edit_field !== 3'd0 || edit_active !== 1'b1) begin
      errors++;
      $display("FAIL single_press: cnt=%b pulse=%b fld=%0d act=%b want 0000001 0 0 1",
               enable_cnt, enable_pulse_1s, edit_field, edit_active);
    end
  endtask

  task automatic test_full_cycle();
    logic [6:0] exp_cnt;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      press_tick(1'b0);
      exp_cnt = 7'b1 << k;
      checks++;
      if (edit_active !== 1'b1 || edit_field !== 3'(k) ||
          enable_cnt !== exp_cnt || enable_pulse_1s !== 1'b0) begin
        errors++;
        $display("FAIL cycle_edit%0d: act=%b fld=%0d cnt=%b pulse=%b want cnt=%b",
                 k, edit_active, edit_field, enable_cnt,
                 enable_pulse_1s, exp_cnt);
      end
      if (k == 0) begin
        display_switch = 1'b1;
        #1;
        checks++;
        if (enable_display !== 7'b0000111) begin
          errors++;
          $display("FAIL edit0_page: got %b want 0000111", enable_display);
        end
        display_switch = 1'b0;
      end
      if (k == 3) begin
        for (int s = 0; s < 2; s++) begin
          display_switch = s[0];
          #1;
          checks++;
          if (enable_display !== 7'b1111000) begin
            errors++;
            $display("FAIL edit3_page sw=%0d: got %b want 1111000",
                     s, enable_display);
          end
        end
        display_switch = 1'b0;
      end
    end
    press_tick(1'b0);
    checks++;
    if (edit_active !== 1'b0 || enable_cnt !== 7'b0 ||
        enable_pulse_1s !== 1'b1 || edit_field !== 3'd0) begin
      errors++;
      $display("FAIL cycle_wrap: act=%b cnt=%b pulse=%b fld=%0d want 0 0 1 0",
               edit_active, enable_cnt, enable_pulse_1s, edit_field);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (3) press_tick(1'b0);
    ticks(9);
    checks++;
    if (edit_active !== 1'b1 || edit_field !== 3'd2) begin
      errors++;
      $display("FAIL timeout_9: act=%b fld=%0d want 1 2", edit_active, edit_field);
    end
    ticks(1);
    checks++;
    if (edit_active !== 1'b0 || enable_pulse_1s !== 1'b1) begin
      errors++;
      $display("FAIL timeout_10: act=%b pulse=%b want 0 1",
               edit_active, enable_pulse_1s);
    end
    do_reset();
    repeat (3) press_tick(1'b0);
    ticks(4);
    press_tick(1'b1);
    ticks(9);
    checks++;
    if (edit_active !== 1'b1 || edit_field !== 3'd3) begin
      errors++;
      $display("FAIL timeout_restart: act=%b fld=%0d want 1 3",
               edit_active, edit_field);
    end
    ticks(1);
    checks++;
    if (edit_active !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after_press: act=%b want 0", edit_active);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (7) press_tick(1'b0);
    ticks(9);
    press_tick(1'b1);
    checks++;
    if (edit_active !== 1'b0 || edit_field !== 3'd0 ||
        enable_pulse_1s !== 1'b1) begin
      errors++;
      $display("FAIL coincide_wrap: act=%b fld=%0d pulse=%b want 0 0 1",
               edit_active, edit_field, enable_pulse_1s);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (edit_active !== 1'b0) begin
      errors++;
      $display("FAIL coincide_wrap_hold: act=%b want 0", edit_active);
    end
    do_reset();
    repeat (2) press_tick(1'b0);
    ticks(9);
    press_tick(1'b1);
    checks++;
    if (edit_active !== 1'b1 || edit_field !== 3'd2) begin
      errors++;
      $display("FAIL coincide_step: act=%b fld=%0d want 1 2",
               edit_active, edit_field);
    end
    ticks(9);
    checks++;
    if (edit_active !== 1'b1 || edit_field !== 3'd2) begin
      errors++;
      $display("FAIL coincide_step_hold: act=%b fld=%0d want 1 2",
               edit_active, edit_field);
    end
    ticks(1);
    checks++;
    if (edit_active !== 1'b0) begin
      errors++;
      $display("FAIL coincide_step_exit: act=%b want 0", edit_active);
    end
  endtask

  task automatic test_blink_reset();
    logic [6:0] exp_disp;
    do_reset();
    repeat (5) press_tick(1'b0);
    checks++;
    if (enable_display !== 7'b1111000 || edit_field !== 3'd4) begin
      errors++;
      $display("FAIL edit4_entry: disp=%b fld=%0d want 1111000 4",
               enable_display, edit_field);
    end
    for (int t = 1; t <= 4; t++) begin
      ticks(1);
      exp_disp = (BLINK && t[0]) ? 7'b1101000 : 7'b1111000;
      checks++;
      if (enable_display !== exp_disp) begin
        errors++;
        $display("FAIL blink_tick%0d: got %b want %b", t, enable_display, exp_disp);
      end
    end
    ticks(1);
    display_switch = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    checks++;
    if (edit_active !== 1'b0 || enable_pulse_1s !== 1'b1 ||
        enable_cnt !== 7'b0 || enable_display !== 7'b0000111 ||
        edit_field !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_edit: act=%b pulse=%b cnt=%b disp=%b fld=%0d",
               edit_active, enable_pulse_1s, enable_cnt,
               enable_display, edit_field);
    end
    @(posedge clk); #1 rst = 1'b1;
    display_switch = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_full_cycle();
    test_timeout();
    test_back_to_back();
    test_blink_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_mode_fsm_param.md
Name: clock_mode_fsm_param

Overview:
- Parametrised successor to the century-clock mode controller; merges mode sequencing and state decode into one block.
- Field count is set by parameter. It adds:
  - on-chip synchroniser and debouncer for the mode button;
  - an edit-mode inactivity timeout;
  - two-page display selection.
- Sits between the raw board inputs and the per-field BCD counters and 7-segment display drivers.

Parameters:
- N_FIELDS, 7: number of time fields (sec, min, hour, day, month, year, century); legal 2..16.
- PAGE_SPLIT, 3: fields 0..PAGE_SPLIT-1 form page 0; PAGE_SPLIT..N_FIELDS-1 form page 1; legal 1..N_FIELDS-1.
- DB_CYCLES, 4: consecutive stable synchronised samples needed to accept a button level; legal >=1.
- TIMEOUT_S, 10: tick_1s pulses without a press before EDIT returns to RUN; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mode_button  in  1  raw, bouncy, active-high push button
- display_switch  in  1  page select in RUN (0 = page 0, 1 = page 1)
- tick_1s  in  1  one-clk pulse per second from the prescaler
- enable_display  out  N_FIELDS  per-field display enable
- enable_cnt  out  N_FIELDS  per-field manual-increment enable (one-hot or zero)
- enable_pulse_1s  out  1  gates tick_1s into the running counters
- edit_active  out  1  high in any EDIT state
- edit_field  out  FW  index of the field being edited, FW = max(1, clog2(N_FIELDS))

Behaviour:
- Reset (rst=0, async):
  - state=RUN, sync FFs=0, debounce counter=0, stable level=0, timeout counter=0, blink phase=0.
  - Outputs during reset: enable_pulse_1s=1, enable_cnt=0, edit_active=0, edit_field=0, enable_display=page-0 mask.
  - Asserting reset mid-EDIT aborts editing; the previous field values are held by the counters, not by this block.
- Input conditioning:
  - mode_button passes through a 2-FF synchroniser.
  - A debounce counter increments while the synchronised value differs from the stable level and clears otherwise.
  - When the count reaches DB_CYCLES, the stable level takes the new value and the counter clears.
  - press = one-clk pulse on a stable 0->1 transition.
  - Latency from a clean raw rise to press is 2+DB_CYCLES clk; the state change follows on the next edge.
  - Bounces shorter than DB_CYCLES cycles produce no press.
- States: RUN, EDIT_k for k = 0..N_FIELDS-1, held in one edit_active flag plus a field index register.
- Transitions (registered, on press):
  - RUN -> EDIT_0.
  - EDIT_k -> EDIT_k+1 for k < N_FIELDS-1.
  - EDIT_(N_FIELDS-1) -> RUN (wrap-around).
- Timeout:
  - In EDIT, the timeout counter increments on each tick_1s and clears on press and on entry to EDIT.
  - When it would reach TIMEOUT_S, state -> RUN and the counter clears.
  - If press and the terminal tick occur in the same cycle, press wins and the timeout is ignored.
  - The counter does not run in RUN; it is disabled when TIMEOUT_S=0.
- Output decode (Moore, combinational from registered state, no glitch-sensitive consumers):
  - RUN:
    - enable_pulse_1s=1, enable_cnt=0, edit_active=0, edit_field=0.
    - enable_display = page mask selected by display_switch (sampled directly; it is a slide switch).
  - EDIT_k:
    - enable_pulse_1s=0, enable_cnt = one-hot bit k, edit_active=1, edit_field=k.
    - enable_display = mask of the page containing k; display_switch is ignored.
- Page masks:
  - Page 0 = bits [PAGE_SPLIT-1:0] set.
  - Page 1 = bits [N_FIELDS-1:PAGE_SPLIT] set.
  - No other bits are ever set.

Optional Feature:
- Macro: CLOCK_MODE_BLINK_EN.
- When defined:
  - A blink phase register toggles on each tick_1s while in EDIT and clears on entry to EDIT.
  - In EDIT_k, bit k of enable_display equals NOT phase, so the field is visible on entry and then off and on each second. Other page bits are unchanged.
  - In RUN, phase is held at 0 with no effect.
- When undefined: no phase register; the edited field is displayed steadily.

Test Plan (defaults unless stated):
- Reset: rst=0 while toggling all inputs -> enable_pulse_1s=1, enable_cnt=0, enable_display=7'b0000111, edit_active=0. Release, then display_switch=1 -> enable_display=7'b1111000.
- Debounce: raw pulses of 3 clk, 8 times -> no state change. Clean high for 10 clk -> exactly one press; edit_active rises 7 clk after the raw rise. enable_cnt=7'b0000001, enable_pulse_1s=0.
- Full cycle: 8 clean presses -> edit_field 0,1,...,6, then RUN. At EDIT_3, enable_display=7'b1111000 regardless of display_switch. The 8th press returns enable_cnt=0, enable_pulse_1s=1.
- Timeout: enter EDIT_2, apply 9 ticks -> still EDIT_2. 10th tick -> RUN. Repeat with a press on tick 5 -> counter restarts, exit occurs 10 ticks after the press.
- Simultaneous events: press coincident with the 10th tick in EDIT_6 -> RUN via wrap, exactly one transition. Coincident in EDIT_1 -> EDIT_2, no timeout exit.
- Reset mid-EDIT plus blink (CLOCK_MODE_BLINK_EN defined): in EDIT_4, bit 4 of enable_display toggles each tick while bits 3,5,6 stay 1. Assert rst -> immediate RUN outputs.
